// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N:1 valid/ready stream multiplexer with a registered output.
//
// The grant comes either from an external select (mode = 0) or from a
// round-robin search among the valid inputs, starting just after the channel
// granted last (mode = 1). The accepted beat lands in the output register one
// cycle after the input handshake. The output register can accept a new beat
// whenever it is empty or being drained in the same cycle, so a continuously
// ready consumer sees one beat per cycle.
//
// Optional build macro STREAM_MUX_PKT_LOCK_EN adds packet locking: after a
// granted beat with in_last = 0, the grant stays on that channel, in either
// mode, until a beat with in_last = 1 is transferred.
//
// Parameters:
//   N      number of input channels (>= 2)
//   WIDTH  data bits per channel
//   SELW   select / channel-id width, derived from N
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   mode       0 = fixed select, 1 = round-robin
//   sel        channel index used in fixed mode
//   in_data    channel i at bits [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (combinational, forced low during reset)
//   in_last    per-channel end-of-packet  (STREAM_MUX_PKT_LOCK_EN only)
//   out_data   registered output data
//   out_chan   channel that supplied out_data
//   out_valid  output register holds a beat
//   out_last   end-of-packet of held beat (STREAM_MUX_PKT_LOCK_EN only)
//   out_ready  consumer accepts the beat
module stream_mux_rr #(
    parameter int N     = 4,
    parameter int WIDTH = 4,
    parameter int SELW  = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode,
    input  logic [SELW-1:0]    sel,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
`ifdef STREAM_MUX_PKT_LOCK_EN
    input  logic [N-1:0]       in_last,
    output logic               out_last,
`endif
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_chan,
    output logic               out_valid,
    input  logic               out_ready
);

    logic [WIDTH-1:0] chan_data [N];

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign chan_data[i] = in_data[i*WIDTH +: WIDTH];
    end

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_chan_q, out_chan_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  ptr_q, ptr_d;

`ifdef STREAM_MUX_PKT_LOCK_EN
    logic             lock_q, lock_d;
    logic [SELW-1:0]  lock_chan_q, lock_chan_d;
    logic             out_last_q, out_last_d;
`endif

    logic             load;
    logic [SELW-1:0]  rr_gnt;
    logic             rr_hit;
    logic [SELW-1:0]  idx;
    logic             fx_vld;
    logic [SELW-1:0]  gnt;
    logic             gnt_vld;
    logic             xfer;

    // Output register is free when empty or being drained this cycle.
    assign load = ~out_valid_q | out_ready;

    // First valid channel at or after ptr+1, wrapping modulo N.
    always_comb begin
        rr_gnt = '0;
        rr_hit = 1'b0;
        idx    = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = SELW'((32'(ptr_q) + k) % N);
            if (!rr_hit && in_valid[idx]) begin
                rr_hit = 1'b1;
                rr_gnt = idx;
            end
        end
    end

    // A select beyond the last channel (N not a power of two) grants nothing.
    assign fx_vld = (32'(sel) < N) ? in_valid[sel] : 1'b0;

    always_comb begin
        gnt     = sel;
        gnt_vld = fx_vld;
        if (mode) begin
            gnt     = rr_gnt;
            gnt_vld = |in_valid;
        end
`ifdef STREAM_MUX_PKT_LOCK_EN
        if (lock_q) begin
            gnt     = lock_chan_q;
            gnt_vld = in_valid[lock_chan_q];
        end
`endif
    end

    assign xfer = load & gnt_vld;

    always_comb begin
        in_ready = '0;
        for (int unsigned i = 0; i < N; i++) begin
            in_ready[i] = xfer & ~rst & (gnt == SELW'(i));
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
`ifdef STREAM_MUX_PKT_LOCK_EN
        lock_d      = lock_q;
        lock_chan_d = lock_chan_q;
        out_last_d  = out_last_q;
`endif
        if (load) begin
            if (gnt_vld) begin
                out_data_d  = chan_data[gnt];
                out_chan_d  = gnt;
                out_valid_d = 1'b1;
                ptr_d       = gnt;
`ifdef STREAM_MUX_PKT_LOCK_EN
                out_last_d  = in_last[gnt];
                lock_d      = ~in_last[gnt];
                lock_chan_d = gnt;
`endif
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= SELW'(N - 1);
`ifdef STREAM_MUX_PKT_LOCK_EN
            lock_q      <= 1'b0;
            lock_chan_q <= '0;
            out_last_q  <= 1'b0;
`endif
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
`ifdef STREAM_MUX_PKT_LOCK_EN
            lock_q      <= lock_d;
            lock_chan_q <= lock_chan_d;
            out_last_q  <= out_last_d;
`endif
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;
`ifdef STREAM_MUX_PKT_LOCK_EN
    assign out_last  = out_last_q;
`endif

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N:1 streaming multiplexer with a registered output; successor to the 4:1 combinational mux.
- Each input is a valid/ready channel; the single output is a valid/ready stream.
- Two selection modes: fixed (external select, as before) and round-robin arbitration among valid inputs.
- Sits between multiple producers and one shared consumer.

Parameters:
- N, 4, number of input channels (N >= 2).
- WIDTH, 4, data width per channel in bits.
- SELW, $clog2(N), width of select and channel-id fields (derived; do not override).

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SELW  channel index used when mode = 0.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready.
- out_data  output  WIDTH  registered output data.
- out_chan  output  SELW  index of the channel that supplied out_data.
- out_valid  output  1  output holds a beat.
- out_ready  input  1  consumer accepts the beat.

Behaviour:
- Reset values: out_valid = 0, out_data = 0, out_chan = 0, rr pointer ptr = N-1, lock cleared. in_ready is combinational and is 0 while rst = 1.
- load = ~out_valid | out_ready. The output register can take a new beat this cycle.
- Grant, fixed mode: gnt = sel, gnt_vld = in_valid[sel]. If sel >= N (N not a power of 2), gnt_vld = 0 and no channel is ever accepted.
- Grant, round-robin mode: gnt is the first i with in_valid[i] = 1, searching ptr+1, ptr+2, ... and wrapping modulo N. gnt_vld = |in_valid.
- in_ready[i] = load & gnt_vld & (gnt == i) & ~rst. At most one in_ready bit is high per cycle.
- Transfer (load & gnt_vld): out_data <= in_data[gnt], out_chan <= gnt, out_valid <= 1, ptr <= gnt. The ptr update happens in both modes.
- load & ~gnt_vld: out_valid <= 0. out_data and out_chan hold their values.
- ~load (out_valid & ~out_ready): out_data, out_chan and out_valid hold. All in_ready = 0.
- Latency: 1 cycle from input handshake to out_valid.
- Throughput: 1 beat per cycle when out_ready is held high.
- Input channels must hold data stable while valid and not ready. The block does not check this.
- A mode or sel change takes effect in the same cycle's grant. ptr is preserved across mode changes.
- Round-robin fairness: with all N inputs valid continuously and out_ready = 1, grants cycle 0,1,...,N-1,0,...
- Reset mid-operation: a held output beat is discarded (out_valid = 0 next cycle). No input is acknowledged during the reset cycle.

Optional Feature:
- Macro: STREAM_MUX_PKT_LOCK_EN.
- Defined: adds input port in_last (N bits) and output port out_last (1 bit, reset 0, registered alongside out_data).
  - A transfer with in_last[gnt] = 0 sets lock and records lock_chan = gnt.
  - While locked, gnt = lock_chan in both modes; sel and the rr search are ignored. gnt_vld = in_valid[lock_chan].
  - A transfer with in_last = 1 clears lock.
  - Reset clears lock.
- Undefined: no in_last or out_last ports. Every beat is arbitrated independently.

Test Plan:
- Fixed mode, N=4, WIDTH=4, in0..in3 = 1100,1101,1110,1111, all valid, out_ready = 1; sel = 0,1,2,3 on successive cycles -> out_data = 1100,1101,1110,1111 one cycle later each, out_chan = 0..3.
- Round-robin, N=4, all valid continuously, out_ready = 1 -> out_chan sequence 0,1,2,3,0,1. With only in_valid = 4'b1010 -> sequence 1,3,1,3.
- Backpressure: out_valid = 1 with out_ready = 0 for 3 cycles -> out_data/out_chan stable, in_ready = 0. Then out_ready = 1 -> next beat loads in the same cycle (back-to-back, no bubble).
- N=3, fixed mode, sel = 3 with all valid -> in_ready = 0, out_valid falls to 0 after draining.
- Assert rst while out_valid = 1 and inputs are valid -> next cycle out_valid = 0, in_ready = 0 during reset. After release, round-robin grants channel 0 first.
- With STREAM_MUX_PKT_LOCK_EN, round-robin: ch1 sends 3 beats (last on the 3rd) while ch0 and ch2 are valid -> out_chan = 1,1,1 then 2, then 0.
